pool_scheduler: RTL
===================

POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 SHALL have parameter POOL_SIZE_LOG2, default 1, log2 of hasher units per device.
REQ-002 SHALL have parameter NONCE_WIDTH, default 32-POOL_SIZE_LOG2, width of core nonce.
REQ-003 SHALL have parameter PRIME_CYCLES, default 4, range 1-255, cycles core is held in reset after job load.
REQ-004 SHALL have parameter RUN_LIMIT, default 2^32, range 1 to 2^40-1, cycles allowed in RUN before exhaustion.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk_in, reset_in.
REQ-006 Ports SHALL be:
- clk_in  input  1  clock.
- reset_in  input  1  synchronous active-high reset.
- job_load_in  input  1  one-cycle pulse; new job config is stable.
- job_abort_in  input  1  one-cycle pulse; stop current job.
- core_success_in  input  1  pool success flag.
- core_nonce_in  input  NONCE_WIDTH  pool nonce, valid with core_success_in.
- core_reset_n_out  output  1  active-low reset to hasher pool.
- ready_out  output  1  result available.
- exhausted_out  output  1  RUN_LIMIT reached without success.
- result_nonce_out  output  32  latched result nonce.
- state_out  output  3  current state code.

Function
REQ-007 SHALL implement states IDLE=0, PRIME=1, RUN=2, DONE=3, EXHAUSTED=4; state_out SHALL equal the state register.
REQ-008 Every output SHALL be a Moore output of registered state or registered data; there SHALL be no combinational path from any input to any output.
REQ-009 core_reset_n_out SHALL be 1 only in RUN and 0 in every other state.
REQ-010 ready_out SHALL be 1 only in DONE; exhausted_out SHALL be 1 only in EXHAUSTED.
REQ-011 job_load_in high in any state SHALL move to PRIME next cycle.
- Same edge: clear result_nonce_out to 0 and load the prime counter with PRIME_CYCLES-1.
REQ-012 PRIME SHALL last exactly PRIME_CYCLES cycles, then enter RUN.
- job_load_in at edge t gives RUN from edge t+1+PRIME_CYCLES.
REQ-013 On RUN entry the run counter (40 bits) SHALL be 0; it SHALL increment by 1 each RUN cycle.
REQ-014 In RUN, core_success_in high SHALL move to DONE next cycle.
- Same edge: latch result_nonce_out = {POOL_SIZE_LOG2 zero bits, core_nonce_in}.
REQ-015 In RUN, no success with run counter == RUN_LIMIT-1 SHALL move to EXHAUSTED; RUN therefore lasts at most RUN_LIMIT cycles.
REQ-016 Success and limit in the same cycle SHALL resolve to DONE.
REQ-017 core_success_in SHALL be ignored in IDLE, PRIME, DONE and EXHAUSTED; result_nonce_out SHALL not change there except through REQ-011.
REQ-018 DONE and EXHAUSTED SHALL hold until job_load_in, job_abort_in or reset_in.
REQ-019 job_abort_in in any non-IDLE state SHALL move to IDLE next cycle; result_nonce_out SHALL hold its value.
REQ-020 Input priority SHALL be: reset_in > job_load_in > job_abort_in > core_success_in > limit.
REQ-021 job_load_in during PRIME or RUN SHALL restart PRIME with a full PRIME_CYCLES count and clear the run counter.

Reset
REQ-022 reset_in high at a clock edge SHALL force IDLE, counters 0 and result_nonce_out 0.
- Outputs after that edge: core_reset_n_out=0, ready_out=0, exhausted_out=0, state_out=0.
REQ-023 reset_in mid-RUN SHALL drop core_reset_n_out to 0 on the next edge and discard any same-cycle success.

Verification
(All scenarios use PRIME_CYCLES=2, RUN_LIMIT=16, POOL_SIZE_LOG2=1.)
REQ-024 Reset, then job_load_in at edge 0:
- state_out=1 at edges 1-2.
- state_out=2 and core_reset_n_out=1 from edge 3.
REQ-025 Success in 5th RUN cycle with core_nonce_in=31'h1234_5678:
- next cycle ready_out=1, core_reset_n_out=0, result_nonce_out=32'h1234_5678.
REQ-026 No success:
- exhausted_out=1 exactly 16 cycles after RUN entry.
- job_load_in then returns state_out=1 with exhausted_out=0 and result_nonce_out=0.
REQ-027 Success asserted in 16th RUN cycle -> state DONE, not EXHAUSTED.
REQ-028 job_load_in and job_abort_in in the same RUN cycle -> PRIME, with RUN re-entered 2 cycles later and run counter 0.
REQ-029 reset_in together with core_success_in in RUN -> IDLE, ready_out=0, result_nonce_out=0.

Source files
------------

// File: rtl/pool_scheduler.sv
// pool_scheduler: sequences a pool of hasher cores through a job.
// A job load holds the pool in reset for PRIME_CYCLES cycles, then releases it
// into RUN until it reports a nonce (DONE) or RUN_LIMIT cycles elapse
// (EXHAUSTED). All outputs decode registered state/data only.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   IDLE      0  | no job; pool held in reset
//   PRIME     1  | job loaded; pool held in reset while config settles
//   RUN       2  | pool released and searching; run counter advancing
//   DONE      3  | pool found a nonce; result latched, pool held in reset
//   EXHAUSTED 4  | RUN_LIMIT cycles spent without success; pool in reset
module pool_scheduler #(
    parameter int          POOL_SIZE_LOG2 = 1,
    parameter int          NONCE_WIDTH    = 32 - POOL_SIZE_LOG2,
    parameter int          PRIME_CYCLES   = 4,
    parameter logic [39:0] RUN_LIMIT      = 40'h01_0000_0000
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   job_load_in,
    input  logic                   job_abort_in,
    input  logic                   core_success_in,
    input  logic [NONCE_WIDTH-1:0] core_nonce_in,
    output logic                   core_reset_n_out,
    output logic                   ready_out,
    output logic                   exhausted_out,
    output logic [31:0]            result_nonce_out,
    output logic [2:0]             state_out
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRIME     = 3'd1,
        ST_RUN       = 3'd2,
        ST_DONE      = 3'd3,
        ST_EXHAUSTED = 3'd4
    } state_t;

    // Prime counter counts down to zero; the cycle it reads zero is the last
    // PRIME cycle, so loading PRIME_CYCLES-1 gives exactly PRIME_CYCLES cycles.
    localparam logic [7:0]  PRIME_LOAD = 8'(PRIME_CYCLES - 1);
    localparam logic [39:0] RUN_LAST   = RUN_LIMIT - 40'd1;
    // Top POOL_SIZE_LOG2 bits of the result identify the device slot and are
    // reported as zero here.
    localparam logic [31:0] NONCE_MASK = 32'hFFFF_FFFF >> POOL_SIZE_LOG2;

    state_t      state_q, state_d;
    logic [7:0]  prime_cnt_q, prime_cnt_d;
    logic [39:0] run_cnt_q, run_cnt_d;
    logic [31:0] result_q, result_d;
    logic [31:0] nonce_ext;

    assign nonce_ext = 32'(core_nonce_in) & NONCE_MASK;

    // State, counters and result register with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            prime_cnt_q <= '0;
            run_cnt_q   <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            run_cnt_q   <= run_cnt_d;
            result_q    <= result_d;
        end
    end

    // Next-state logic; priority is load, abort, success, then run limit.
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        run_cnt_d   = '0;
        result_d    = result_q;

        if (job_load_in) begin
            state_d     = ST_PRIME;
            prime_cnt_d = PRIME_LOAD;
            result_d    = '0;
        end else if (job_abort_in && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_PRIME: begin
                    if (prime_cnt_q == 8'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        prime_cnt_d = prime_cnt_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (core_success_in) begin
                        state_d  = ST_DONE;
                        result_d = nonce_ext;
                    end else if (run_cnt_q == RUN_LAST) begin
                        state_d = ST_EXHAUSTED;
                    end else begin
                        run_cnt_d = run_cnt_q + 40'd1;
                    end
                end
                ST_IDLE, ST_DONE, ST_EXHAUSTED: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign state_out        = state_q;
    assign core_reset_n_out = (state_q == ST_RUN);
    assign ready_out        = (state_q == ST_DONE);
    assign exhausted_out    = (state_q == ST_EXHAUSTED);
    assign result_nonce_out = result_q;

endmodule
